// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, link register, writeback entry type.
// Used by the writeback collector, the register file and decode.
package regfile_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_LINK = 5'd31;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Return address written by branch-and-link; wraps modulo 2^DW.
    function automatic logic [DW-1:0] link_value(input logic [DW-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/wb_multipush_fifo.sv
// DEPTH-entry writeback FIFO accepting 0-3 in-order pushes and 0-1 pop per cycle.
// Pushes are compacted so that enabled slots land in consecutive entries.
module wb_multipush_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            push_i,
    input  wb_entry_t [2:0]       din_i,
    input  logic                  pop_i,
    output wb_entry_t             head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      off_s [3];
    logic [1:0]      npush_s;

    // Slot offset of each push among this cycle's enabled pushes, plus pointer/count next state.
    always_comb begin
        off_s[0] = 2'd0;
        off_s[1] = {1'b0, push_i[0]};
        off_s[2] = {1'b0, push_i[0]} + {1'b0, push_i[1]};
        npush_s  = off_s[2] + {1'b0, push_i[2]};
        wr_ptr_d = wr_ptr_q + PW'(npush_s);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(npush_s) - CW'(pop_i);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; slots outside the occupied range are don't-care, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (push_i[k]) begin
                mem_q[wr_ptr_q + PW'(off_s[k])] <= din_i[k];
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback collector: link > mem > alu arbitration, output stage, RAW scoreboard.
// Optional REGFILE_WB_R0_DISCARD_EN: rd = 0 results are acknowledged but never written.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          link_valid,
    input  logic [DW-1:0] link_pc,
    output logic          link_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic [AW-1:0] q_rs1,
    input  logic [AW-1:0] q_rs2,
    output logic          q_busy1,
    output logic          q_busy2
);

`ifdef REGFILE_WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int SW   = $clog2(DEPTH + 2);
    localparam int NREG = 1 << AW;

    logic [CW-1:0]   count_s;
    logic [CW-1:0]   free_s;
    logic            pop_s;
    logic            mem_keep_s;
    logic            alu_keep_s;
    logic [1:0]      alu_ahead_s;
    logic [2:0]      push_s;
    wb_entry_t [2:0] din_s;
    wb_entry_t       head_s;

    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;

    logic [SW-1:0]   sb_q [NREG];
    logic [SW-1:0]   sb_d [NREG];

    // Free slots include the one released by this cycle's pop; readies never look at their own valid.
    always_comb begin
        pop_s       = (count_s != {CW{1'b0}});
        free_s      = CW'(DEPTH) - count_s + CW'(pop_s);
        mem_keep_s  = !R0_DISCARD || (mem_rd != {AW{1'b0}});
        alu_keep_s  = !R0_DISCARD || (alu_rd != {AW{1'b0}});
        alu_ahead_s = {1'b0, link_valid} + {1'b0, mem_valid & mem_keep_s};
        link_ready  = !reset && (free_s != {CW{1'b0}});
        mem_ready   = !reset && (free_s > CW'(link_valid));
        alu_ready   = !reset && (free_s > CW'(alu_ahead_s));
        push_s[0]   = link_valid & link_ready;
        push_s[1]   = mem_valid & mem_ready & mem_keep_s;
        push_s[2]   = alu_valid & alu_ready & alu_keep_s;
        din_s[0].rd   = REG_LINK;
        din_s[0].data = link_value(link_pc);
        din_s[1].rd   = mem_rd;
        din_s[1].data = mem_data;
        din_s[2].rd   = alu_rd;
        din_s[2].data = alu_data;
    end

    wb_multipush_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .din_i   (din_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .count_o (count_s)
    );

    // Output stage: address and data hold their last values while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {DW{1'b0}};
        end else begin
            wr_en_q <= pop_s;
            if (pop_s) begin
                wr_addr_q <= head_s.rd;
                wr_data_q <= head_s.data;
            end
        end
    end

    // Pending count per register: up to three accepts in, one output-stage write out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sb_d[r] = sb_q[r]
                    + SW'(push_s[0] && (REG_LINK == AW'(r)))
                    + SW'(push_s[1] && (mem_rd == AW'(r)))
                    + SW'(push_s[2] && (alu_rd == AW'(r)))
                    - SW'(wr_en_q && (wr_addr_q == AW'(r)));
        end
    end

    // Scoreboard counter registers.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset) begin
                sb_q[r] <= {SW{1'b0}};
            end else begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign q_busy1 = (sb_q[q_rs1] != {SW{1'b0}});
    assign q_busy2 = (sb_q[q_rs2] != {SW{1'b0}});

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed test-plan steps followed by random traffic,
// all compared against a queue-based model of the writeback path.
module tb_regfile_writeback;

    localparam int DEPTH = 8;
`ifdef REGFILE_WB_R0_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        link_valid, mem_valid, alu_valid;
    logic [31:0] link_pc, mem_data, alu_data;
    logic [4:0]  mem_rd, alu_rd, q_rs1, q_rs2;
    logic        link_ready, mem_ready, alu_ready;
    logic        wr_en, q_busy1, q_busy2;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .link_valid(link_valid), .link_pc(link_pc), .link_ready(link_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Model: queued entries in order, plus the register-file write port state.
    ent_t        mq[$];
    logic        m_en   = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    bit          acc_l, acc_m, acc_a;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit keep(input logic [4:0] rd);
        return !(DISCARD && rd == 5'd0);
    endfunction

    function automatic int free_slots();
        return DEPTH - mq.size() + ((mq.size() != 0) ? 1 : 0);
    endfunction

    // Writes still owed to register r: queued entries plus one sitting on the write port.
    function automatic int pend(input logic [4:0] r);
        int n = 0;
        foreach (mq[i]) if (mq[i].rd == r) n++;
        if (m_en && m_addr == r) n++;
        return n;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit el, em, ea;
        int fr, ahead;
        ent_t e;
        @(negedge clk);
        fr    = free_slots();
        ahead = (link_valid ? 1 : 0) + ((mem_valid && keep(mem_rd)) ? 1 : 0);
        el = !reset && fr > 0;
        em = !reset && fr > (link_valid ? 1 : 0);
        ea = !reset && fr > ahead;
        chk("link_ready", link_ready, el);
        chk("mem_ready", mem_ready, em);
        chk("alu_ready", alu_ready, ea);
        chk("wr_en", wr_en, m_en);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("q_busy1", q_busy1, pend(q_rs1) != 0);
        chk("q_busy2", q_busy2, pend(q_rs2) != 0);
        acc_l = link_valid && el;
        acc_m = mem_valid && em;
        acc_a = alu_valid && ea;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        end else begin
            if (mq.size() != 0) begin
                e = mq.pop_front();
                m_en = 1'b1; m_addr = e.rd; m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            if (acc_l) begin
                e.rd = 5'd31; e.data = link_pc + 32'd1; mq.push_back(e);
            end
            if (acc_m && keep(mem_rd)) begin
                e.rd = mem_rd; e.data = mem_data; mq.push_back(e);
            end
            if (acc_a && keep(alu_rd)) begin
                e.rd = alu_rd; e.data = alu_data; mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        link_valid = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    endtask

    initial begin
        bit saw_drop;
        reset = 1'b1;
        idle();
        link_pc = 32'd0; mem_rd = 5'd0; mem_data = 32'd0; alu_rd = 5'd0; alu_data = 32'd0;
        q_rs1 = 5'd0; q_rs2 = 5'd31;
        @(posedge clk); #1;
        cycle();
        chk("reset_wr_en", wr_en, 1'b0);
        chk("reset_wr_data", wr_data, 32'd0);
        reset = 1'b0;

        // Single ALU write to r5.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; q_rs1 = 5'd5;
        cycle();
        idle();
        chk("alu_busy_c1", q_busy1, 1'b1);
        cycle();
        chk("alu_wr_en", wr_en, 1'b1);
        chk("alu_wr_addr", wr_addr, 5'd5);
        chk("alu_wr_data", wr_data, 32'hDEADBEEF);
        chk("alu_busy_c2", q_busy1, 1'b1);
        cycle();
        chk("alu_busy_clr", q_busy1, 1'b0);

        // All three producers in one cycle.
        link_valid = 1'b1; link_pc = 32'h100;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        q_rs1 = 5'd3; q_rs2 = 5'd31;
        cycle();
        idle();
        cycle();
        chk("tri_w1_addr", wr_addr, 5'd31);
        chk("tri_w1_data", wr_data, 32'h101);
        cycle();
        chk("tri_w2_addr", wr_addr, 5'd3);
        chk("tri_w2_data", wr_data, 32'h11);
        chk("tri_r3_busy", q_busy1, 1'b1);
        cycle();
        chk("tri_w3_data", wr_data, 32'h22);
        chk("tri_r3_busy_last", q_busy1, 1'b1);
        cycle();
        chk("tri_r3_clear", q_busy1, 1'b0);

        // Fill with continuous mem + alu traffic, then drain.
        saw_drop = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1000;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h2000;
        q_rs1 = 5'd7; q_rs2 = 5'd9;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (acc_m) mem_data = mem_data + 32'd1;
            if (acc_a) alu_data = alu_data + 32'd1;
            if (!alu_ready) saw_drop = 1'b1;
        end
        chk("fill_alu_ready_drop", saw_drop, 1'b1);
        idle();
        for (int i = 0; i < 12; i++) cycle();

        // Wrapping link PC.
        link_valid = 1'b1; link_pc = 32'hFFFFFFFF;
        cycle();
        idle();
        cycle();
        chk("wrap_addr", wr_addr, 5'd31);
        chk("wrap_data", wr_data, 32'h0);
        cycle();

        // Reset with five entries queued.
        mem_valid = 1'b1; alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (acc_m) mem_data = mem_data + 32'd1;
            if (acc_a) alu_data = alu_data + 32'd1;
        end
        idle();
        reset = 1'b1;
        cycle();
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy1", q_busy1, 1'b0);
        chk("rst_busy2", q_busy2, 1'b0);
        chk("rst_link_ready", link_ready, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCAFE0001;
        cycle();
        idle();
        cycle();
        chk("post_rst_addr", wr_addr, 5'd12);
        chk("post_rst_data", wr_data, 32'hCAFE0001);
        cycle();

        // ALU write to r0.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55; q_rs1 = 5'd0;
        cycle();
        chk("r0_accepted", acc_a, 1'b1);
        idle();
        cycle();
        chk("r0_wr_en", wr_en, DISCARD ? 1'b0 : 1'b1);
        cycle();

        // Random traffic with occasional mid-stream reset.
        acc_l = 1'b0; acc_m = 1'b0; acc_a = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!link_valid || acc_l) begin
                link_valid = ($urandom_range(0, 99) < 25);
                link_pc = $urandom();
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 99) < 55);
                mem_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
                mem_data = $urandom();
            end
            if (!alu_valid || acc_a) begin
                alu_valid = ($urandom_range(0, 99) < 65);
                alu_rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
                alu_data = $urandom();
            end
            q_rs1 = 5'($urandom_range(0, 7));
            q_rs2 = ($urandom_range(0, 1) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 12; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
